// File: rtl/csa_resolve25.sv
// csa_resolve25: chunk-serial carry-save resolver, res = s_in + 2*c_in; ovf port under CSA_RESOLVE_OVF_EN
module csa_resolve25 #(
  parameter int CHUNK = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] s_in,
  input  logic [24:0] c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] res
`ifdef CSA_RESOLVE_OVF_EN
  ,
  output logic        ovf
`endif
);
  localparam int NCHUNK = 27 / CHUNK;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [26:0] a, b, res_nxt;
  logic [4:0] k;
  logic carry, last;
  logic [CHUNK:0] sum;
  assign last = k == 5'(NCHUNK - 1);
  assign sum = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
  always_comb begin
    res_nxt = res;
    res_nxt[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // the carry out of the final chunk is registered but never consumed
  always_ff @(posedge clk)
    if (rst) begin
      a <= '0;
      b <= '0;
      res <= '0;
      k <= '0;
      carry <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a <= {2'b0, s_in};
      b <= {1'b0, c_in, 1'b0};
      k <= '0;
      carry <= 1'b0;
    end else if (state == BUSY) begin
      res <= res_nxt;
      carry <= sum[CHUNK];
      k <= k + 5'd1;
    end
`ifdef CSA_RESOLVE_OVF_EN
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else if (state == BUSY && last) ovf <= |res_nxt[26:25];
`endif
endmodule

// File: tb/tb_csa_resolve25.sv
// tb_csa_resolve25: drives CHUNK=9/1/27 instances in lockstep against an arithmetic reference model
module tb_csa_resolve25;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [24:0] s_in = '0, c_in = '0;
  logic [2:0] in_ready, out_valid, ovf;
  logic [26:0] res [3];
  int lat [3] = '{9 / 9 * 3, 27, 1};
  int checks = 0, fails = 0;
  always #5 clk = ~clk;

  csa_resolve25 #(.CHUNK(9)) u9 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .s_in(s_in), .c_in(c_in), .out_valid(out_valid[0]), .out_ready(out_ready), .res(res[0])
`ifdef CSA_RESOLVE_OVF_EN
    , .ovf(ovf[0])
`endif
  );
  csa_resolve25 #(.CHUNK(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .s_in(s_in), .c_in(c_in), .out_valid(out_valid[1]), .out_ready(out_ready), .res(res[1])
`ifdef CSA_RESOLVE_OVF_EN
    , .ovf(ovf[1])
`endif
  );
  csa_resolve25 #(.CHUNK(27)) u27 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .s_in(s_in), .c_in(c_in), .out_valid(out_valid[2]), .out_ready(out_ready), .res(res[2])
`ifdef CSA_RESOLVE_OVF_EN
    , .ovf(ovf[2])
`endif
  );
`ifndef CSA_RESOLVE_OVF_EN
  assign ovf = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid = 0;
    step();
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || res[i] !== 27'd0 || ovf[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset dut%0d: rdy=%b vld=%b res=%h ovf=%b, want rdy=1 vld=0 res=0 ovf=0",
                 i, in_ready[i], out_valid[i], res[i], ovf[i]);
      end
    end
  endtask

  // one transaction through all three instances with out_ready held high
  task automatic txn(input logic [24:0] s, input logic [24:0] c, input string tag);
    logic [26:0] exp;
    logic exp_ovf;
    bit seen [3];
    exp = 27'(s) + 27'(c) * 27'd2;
    exp_ovf = exp > 27'h1FFFFFF;
    out_ready = 1;
    in_valid = 1;
    s_in = s;
    c_in = c;
    step();
    in_valid = 0;
    for (int n = 1; n <= 32; n++) begin
      s_in = 25'($urandom);
      c_in = 25'($urandom);
      step();
      for (int i = 0; i < 3; i++)
        if (out_valid[i] && !seen[i]) begin
          seen[i] = 1;
          checks++;
          if (n !== lat[i] || res[i] !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: latency=%0d res=%h, want latency=%0d res=%h", tag, i, n, res[i], lat[i], exp);
          end
`ifdef CSA_RESOLVE_OVF_EN
          checks++;
          if (ovf[i] !== exp_ovf) begin
            fails++;
            $display("FAIL %s_ovf dut%0d: ovf=%b, want %b", tag, i, ovf[i], exp_ovf);
          end
`endif
        end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!seen[i] || in_ready[i] !== 1'b1) begin
        fails++;
        $display("FAIL %s_done dut%0d: seen=%0d rdy=%b, want seen=1 rdy=1", tag, i, seen[i], in_ready[i]);
      end
    end
  endtask

  task automatic test_vectors();
    txn(25'd1, 25'd1, "ones");
    txn(25'h1FF, 25'h1, "chunk_carry");
    txn(25'h1FFFFFF, 25'h1FFFFFF, "max");
    txn(25'h0, 25'h0, "zero");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) txn(25'($urandom), 25'($urandom), "random");
  endtask

  task automatic test_stall();
    logic [26:0] exp, held [3];
    logic [2:0] done;
    int budget;
    exp = 27'h0ABCDE + 27'h012345 * 27'd2;
    out_ready = 0;
    in_valid = 1;
    s_in = 25'h0ABCDE;
    c_in = 25'h012345;
    step();
    budget = 0;
    while (out_valid !== 3'b111 && budget < 40) begin
      s_in = 25'($urandom);
      c_in = 25'($urandom);
      step();
      budget++;
    end
    checks++;
    if (out_valid !== 3'b111) begin
      fails++;
      $display("FAIL stall_wait: out_valid=%b, want 111", out_valid);
    end
    for (int i = 0; i < 3; i++) held[i] = res[i];
    for (int n = 0; n < 10; n++) begin
      in_valid = 1;
      s_in = 25'($urandom);
      c_in = 25'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0 || res[i] !== exp || res[i] !== held[i]) begin
          fails++;
          $display("FAIL stall dut%0d cyc%0d: vld=%b rdy=%b res=%h, want vld=1 rdy=0 res=%h", i, n, out_valid[i], in_ready[i], res[i], exp);
        end
      end
    end
    in_valid = 0;
    out_ready = 1;
    step();
    done = in_ready & ~out_valid;
    checks++;
    if (done !== 3'b111) begin
      fails++;
      $display("FAIL stall_release: idle=%b, want 111", done);
    end
  endtask

  task automatic test_reset_busy();
    out_ready = 1;
    in_valid = 1;
    s_in = 25'h1FFFFFF;
    c_in = 25'h1234;
    step();
    in_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || res[i] !== 27'd0 || ovf[i] !== 1'b0) begin
        fails++;
        $display("FAIL rst_busy dut%0d: rdy=%b vld=%b res=%h ovf=%b, want 1 0 0 0", i, in_ready[i], out_valid[i], res[i], ovf[i]);
      end
    end
    for (int n = 0; n < 30; n++) begin
      step();
      checks++;
      if (out_valid !== 3'b000) begin
        fails++;
        $display("FAIL rst_no_valid cyc%0d: out_valid=%b, want 000", n, out_valid);
      end
    end
    txn(25'd5, 25'd2, "after_rst");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_stall();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
